// File: rtl/dram_result_uart_framer_pkg.sv
// Shared definitions for the DRAM result path consumers.
//   - state_t    : framer FSM states
//   - HDR0/HDR1  : frame header bytes
//   - NUM_CORES  : default number of result bytes per frame
//   - frame_len(): bytes per frame for a core count and checksum option
package dram_io_pkg;

   localparam int          NUM_CORES    = 16;
   localparam logic [7:0]  HDR0         = 8'hA5;
   localparam logic [7:0]  HDR1         = 8'h5A;
   localparam int          BUSY_TIMEOUT = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Two header bytes, the data bytes, and an optional trailing checksum.
   function automatic int frame_len(input int n_cores, input bit csum_en);
      return n_cores + 2 + (csum_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/dram_result_uart_framer_rising_edge_det.sv
// Registered rising-edge detector.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (history register cleared)
//   i_sig  : level input
//   o_rise : high for the cycle in which i_sig is high and was low last cycle
module rising_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sig_q <= 1'b0;
      else        r_sig_q <= i_sig;
   end

   assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/dram_result_uart_framer.sv
// Frames the per-core DRAM result bytes for the byte-wide UART transmitter.
// On a rising edge of rd_done all result bytes are snapshotted, then sent as
// HDR0 HDR1 D1..Dn [CSUM], one uart_en pulse per byte, pacing on uart_busy.
// Build option: define FRAME_CHECKSUM_EN to append the 8-bit data checksum.
// Ports:
//   clk_100m, rst_n : clock, asynchronous active-low reset
//   rd_done         : read-complete level; rising edge starts a frame
//   dram_data       : result bytes, core 1 in [7:0]
//   uart_busy       : transmitter busy
//   uart_en/din     : byte strobe and byte to transmit
//   frame_busy      : frame in progress
//   frame_done      : one-cycle pulse at end of frame
//   overrun         : one-cycle pulse, start request dropped while busy
//
// state   | meaning
// IDLE    | waiting for rd_done rising edge
// LOAD    | present next byte, pulse uart_en
// WAIT_HI | waiting for uart_busy to rise (bounded by BUSY_TIMEOUT)
// WAIT_LO | waiting for uart_busy to fall
// DONE    | frame_done pulse, clear checksum
module dram_result_uart_framer
   import dram_io_pkg::*;
#(
   parameter int         P_NUM_CORES    = NUM_CORES,
   parameter logic [7:0] P_HDR0         = HDR0,
   parameter logic [7:0] P_HDR1         = HDR1,
   parameter int         P_BUSY_TIMEOUT = BUSY_TIMEOUT
) (
   input  logic                     clk_100m,
   input  logic                     rst_n,
   input  logic                     rd_done,
   input  logic [8*P_NUM_CORES-1:0] dram_data,
   input  logic                     uart_busy,
   output logic                     uart_en,
   output logic [7:0]               uart_din,
   output logic                     frame_busy,
   output logic                     frame_done,
   output logic                     overrun
);

`ifdef FRAME_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int LAST = frame_len(P_NUM_CORES, CSUM_EN) - 1;
   localparam int IW   = $clog2(LAST + 1);

   state_t                   r_state;
   logic [8*P_NUM_CORES-1:0] r_buf;
   logic [IW-1:0]            r_idx;
   logic [7:0]               r_tmr;
   logic                     r_uart_en;
   logic [7:0]               r_uart_din;
   logic                     r_frame_busy;
   logic                     r_frame_done;
   logic                     r_overrun;
`ifdef FRAME_CHECKSUM_EN
   logic [7:0]               r_csum;
`endif

   logic                     w_start;
   logic [7:0]               w_byte;
   logic                     w_is_data;

   rising_edge_det u_rd_done_edge (
      .clk    (clk_100m),
      .rst_n  (rst_n),
      .i_sig  (rd_done),
      .o_rise (w_start)
   );

   // Byte selected by the frame index.
   always_comb begin
      w_byte    = 8'h00;
      w_is_data = 1'b0;
      if (r_idx == '0) begin
         w_byte = P_HDR0;
      end else if (r_idx == IW'(1)) begin
         w_byte = P_HDR1;
      end else if (int'(r_idx) <= P_NUM_CORES + 1) begin
         w_is_data = 1'b1;
         w_byte    = r_buf[8*(int'(r_idx)-2) +: 8];
      end
`ifdef FRAME_CHECKSUM_EN
      else begin
         w_byte = r_csum;
      end
`endif
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_buf        <= '0;
         r_idx        <= '0;
         r_tmr        <= '0;
         r_uart_en    <= 1'b0;
         r_uart_din   <= 8'h00;
         r_frame_busy <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
         r_csum       <= 8'h00;
`endif
      end else begin
         r_uart_en    <= 1'b0;
         r_frame_done <= 1'b0;
         // Any start outside IDLE (including DONE) is dropped and flagged.
         r_overrun    <= w_start && (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_buf        <= dram_data;
                  r_frame_busy <= 1'b1;
                  r_idx        <= '0;
                  r_state      <= LOAD;
               end
            end
            LOAD: begin
               r_uart_din <= w_byte;
               r_uart_en  <= 1'b1;
               r_tmr      <= 8'(P_BUSY_TIMEOUT - 1);
`ifdef FRAME_CHECKSUM_EN
               if (w_is_data) r_csum <= r_csum + w_byte;
`endif
               r_state    <= WAIT_HI;
            end
            WAIT_HI: begin
               // A transmitter that never acknowledges must not stall the frame.
               if (uart_busy || (r_tmr == 8'd0)) r_state <= WAIT_LO;
               else                              r_tmr   <= r_tmr - 8'd1;
            end
            WAIT_LO: begin
               if (!uart_busy) begin
                  if (r_idx == IW'(LAST)) begin
                     r_frame_done <= 1'b1;
                     r_frame_busy <= 1'b0;
                     r_state      <= DONE;
                  end else begin
                     r_idx   <= r_idx + IW'(1);
                     r_state <= LOAD;
                  end
               end
            end
            DONE: begin
`ifdef FRAME_CHECKSUM_EN
               r_csum  <= 8'h00;
`endif
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign uart_en    = r_uart_en;
   assign uart_din   = r_uart_din;
   assign frame_busy = r_frame_busy;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_dram_result_uart_framer.sv
module tb_dram_result_uart_framer;

   localparam int NB      = 16;
   localparam int TIMEOUT = 16;
`ifdef FRAME_CHECKSUM_EN
   localparam int FLEN = NB + 3;
`else
   localparam int FLEN = NB + 2;
`endif

   logic            clk_100m;
   logic            rst_n;
   logic            rd_done;
   logic [8*NB-1:0] dram_data;
   logic            uart_busy;
   logic            uart_en;
   logic [7:0]      uart_din;
   logic            frame_busy;
   logic            frame_done;
   logic            overrun;

   dram_result_uart_framer dut (
      .clk_100m   (clk_100m),
      .rst_n      (rst_n),
      .rd_done    (rd_done),
      .dram_data  (dram_data),
      .uart_busy  (uart_busy),
      .uart_en    (uart_en),
      .uart_din   (uart_din),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   initial clk_100m = 1'b0;
   always #5 clk_100m = ~clk_100m;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int cyc = 0;
   int done_cnt, ovr_cnt, min_gap, max_gap, last_en;

   always @(posedge clk_100m) cyc++;

   always @(negedge clk_100m) begin
      if (rst_n) begin
         if (uart_en) begin
            got_q.push_back(uart_din);
            if (last_en >= 0) begin
               if (cyc - last_en < min_gap) min_gap = cyc - last_en;
               if (cyc - last_en > max_gap) max_gap = cyc - last_en;
            end
            last_en = cyc;
         end
         if (frame_done) done_cnt++;
         if (overrun)    ovr_cnt++;
      end
   end

   task automatic clear_mon();
      got_q.delete();
      done_cnt = 0;
      ovr_cnt  = 0;
      min_gap  = 1000000;
      max_gap  = 0;
      last_en  = -1;
   endtask

   // ---------------- uart_send responder ----------------
   bit no_busy = 1'b0;
   int pend = -1;
   int left = 0;
   int blen = 1;

   always @(negedge clk_100m) begin
      if (!rst_n) begin
         uart_busy = 1'b0;
         pend = -1;
         left = 0;
      end else begin
         if (left > 0) begin
            left--;
            if (left == 0) uart_busy = 1'b0;
         end else if (pend == 0) begin
            uart_busy = 1'b1;
            left = blen;
            pend = -1;
         end else if (pend > 0) begin
            pend--;
         end
         if (uart_en && !no_busy) begin
            pend = $urandom_range(0, 2);
            blen = $urandom_range(1, 5);
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic void build_exp(input logic [8*NB-1:0] d);
      int sum;
      sum = 0;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      for (int k = 0; k < NB; k++) begin
         exp_q.push_back(d[8*k +: 8]);
         sum = sum + int'(d[8*k +: 8]);
      end
`ifdef FRAME_CHECKSUM_EN
      exp_q.push_back(8'(sum % 256));
`endif
   endfunction

   task automatic wait_bytes(input int n, input string name);
      int i;
      for (i = 0; i < 5000 && got_q.size() < n; i++) @(negedge clk_100m);
      if (got_q.size() < n) chk({name, "_byte_wait_timeout"}, got_q.size(), n);
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk_100m);
      if (done_cnt == 0) chk({name, "_done_timeout"}, 0, 1);
   endtask

   task automatic start_frame(input logic [8*NB-1:0] d);
      @(negedge clk_100m);
      dram_data = d;
      rd_done   = 1'b1;
   endtask

   task automatic run_frame(input logic [8*NB-1:0] d, input bit hold, input string name);
      clear_mon();
      start_frame(d);
      wait_done(name);
      repeat (3) @(negedge clk_100m);
      if (!hold) rd_done = 1'b0;
      repeat (2) @(negedge clk_100m);
   endtask

   task automatic check_frame(input logic [8*NB-1:0] d, input string name);
      int n;
      build_exp(d);
      chk({name, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_min_gap_ge3"}, int'(min_gap >= 3), 1);
   endtask

   typedef struct {
      logic [8*NB-1:0] data;
      logic [7:0]      csum;
   } vec_t;
   vec_t vecs[5];

   initial begin
      logic [8*NB-1:0] d0, d1;
      logic [7:0] last_exp;

      vecs[0] = '{{16{8'h55}}, 8'h50};
      vecs[1] = '{128'h100F0E0D0C0B0A090807060504030201, 8'h88};
      vecs[2] = '{{16{8'hFF}}, 8'hF0};
      vecs[3] = '{{16{8'h00}}, 8'h00};
      vecs[4] = '{128'h80000000_00000000_00000000_00000080, 8'h00};

      rst_n     = 1'b0;
      rd_done   = 1'b0;
      dram_data = '0;
      clear_mon();
      repeat (3) @(negedge clk_100m);
      chk("rst_uart_en", int'(uart_en), 0);
      chk("rst_uart_din", int'(uart_din), 0);
      chk("rst_frame_busy", int'(frame_busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_100m);
      chk("idle_uart_en", int'(uart_en), 0);
      chk("idle_frame_busy", int'(frame_busy), 0);

      // Table-driven frames with hand-computed checksums.
      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].data, 1'b0, $sformatf("vec%0d", v));
         check_frame(vecs[v].data, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_count", v), got_q.size(), FLEN);
`ifdef FRAME_CHECKSUM_EN
         last_exp = vecs[v].csum;
`else
         last_exp = vecs[v].data[8*NB-1 -: 8];
`endif
         if (got_q.size() > 0)
            chk($sformatf("vec%0d_last", v), int'(got_q[got_q.size()-1]), int'(last_exp));
         chk($sformatf("vec%0d_no_overrun", v), ovr_cnt, 0);
      end

      // Randomized frames against the model.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < NB/4; k++) d0[32*k +: 32] = $urandom;
         run_frame(d0, 1'b0, $sformatf("rnd%0d", r));
         check_frame(d0, $sformatf("rnd%0d", r));
      end

      // rd_done held high: exactly one frame.
      d0 = {8{8'h3C, 8'hC3}};
      run_frame(d0, 1'b1, "hold");
      check_frame(d0, "hold");
      clear_mon();
      repeat (1000) @(negedge clk_100m);
      chk("hold_no_more_bytes", got_q.size(), 0);
      chk("hold_no_more_done", done_cnt, 0);
      chk("hold_no_overrun", ovr_cnt, 0);
      rd_done = 1'b0;
      repeat (2) @(negedge clk_100m);

      // Second rising edge mid-frame: overrun, original data kept.
      for (int k = 0; k < NB/4; k++) d0[32*k +: 32] = $urandom;
      for (int k = 0; k < NB/4; k++) d1[32*k +: 32] = ~d0[32*k +: 32];
      clear_mon();
      start_frame(d0);
      wait_bytes(5, "ovr");
      rd_done = 1'b0;
      @(negedge clk_100m);
      dram_data = d1;
      rd_done   = 1'b1;
      @(negedge clk_100m);
      @(negedge clk_100m);
      chk("ovr_busy_kept", int'(frame_busy), 1);
      wait_done("ovr");
      repeat (3) @(negedge clk_100m);
      rd_done = 1'b0;
      repeat (2) @(negedge clk_100m);
      chk("ovr_pulse_cycles", ovr_cnt, 1);
      check_frame(d0, "ovr");

      // Transmitter never asserts busy: each byte advances on the timeout.
      no_busy = 1'b1;
      d0 = vecs[1].data;
      run_frame(d0, 1'b0, "tmo");
      check_frame(d0, "tmo");
      chk("tmo_gap_min", int'(min_gap >= TIMEOUT + 1), 1);
      chk("tmo_gap_max", int'(max_gap <= TIMEOUT + 3), 1);
      no_busy = 1'b0;

      // Reset during byte 9 aborts; next frame restarts from the header.
      for (int k = 0; k < NB/4; k++) d0[32*k +: 32] = $urandom;
      clear_mon();
      start_frame(d0);
      wait_bytes(9, "rst");
      @(posedge clk_100m);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_uart_en", int'(uart_en), 0);
      chk("midrst_uart_din", int'(uart_din), 0);
      chk("midrst_frame_busy", int'(frame_busy), 0);
      chk("midrst_frame_done", int'(frame_done), 0);
      chk("midrst_overrun", int'(overrun), 0);
      rd_done = 1'b0;
      repeat (3) @(negedge clk_100m);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_100m);
      chk("postrst_idle", int'(frame_busy), 0);
      for (int k = 0; k < NB/4; k++) d1[32*k +: 32] = $urandom;
      run_frame(d1, 1'b0, "postrst");
      check_frame(d1, "postrst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
